// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data requesters, with a saturating count of
// back-to-back data grants that forces a fetch grant once it reaches its limit.
module mem_port_arbiter_prio
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_i,
    output logic grant_d
);

    localparam int SW = streak_width(MAX_D_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          fetch_due;

    assign fetch_due = if_req && (streak == STREAK_MAX);
    assign grant_d   = d_req && !fetch_due;
    assign grant_i   = if_req && !grant_d;

    // Only data grants that starve a waiting fetch extend the streak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_en) begin
            if (grant_d && if_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_d || grant_i) begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port,
// one transaction in flight, data preferred with bounded fetch starvation.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no transaction; pick a winner when any request is present
//   ST_ISSUE | m_req held with the winner's command until m_gnt
//   ST_WAIT  | command accepted; waiting for m_rvalid
//   ST_RESP  | owner's ready pulse for one cycle, requests ignored
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    arb_state_e state;
    owner_e     owner;
    logic       grant_i;
    logic       grant_d;

    mem_port_arbiter_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_req   (d_req),
        .grant_en(state == ST_IDLE),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_rdata <= '0;
            if_ready <= 1'b0;
            d_rdata  <= '0;
            d_ready  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        owner   <= OWN_D;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end else if (grant_i) begin
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                        m_wdata <= '0;
                        owner   <= OWN_I;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_gnt) begin
                        m_req <= 1'b0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Store acks also return m_rdata to the data port; it is don't-care there.
                    if (m_rvalid) begin
                        if (owner == OWN_D) begin
                            d_rdata <= m_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            if_rdata <= m_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    owner    <= OWN_NONE;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAX_D = 4;

    localparam int P_FREE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_ACK  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_D_STREAK(MAX_D)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory and requester models ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t        acc_log[$];
    logic [31:0] mem [logic [31:0]];
    int          gnt_pct = 100, rv_min = 1, rv_max = 1, if_pct = 0, d_pct = 0;
    int          rv_cnt = 0;
    logic [31:0] rv_data;
    logic        force_rv = 1'b0;
    logic [31:0] force_data;
    logic        if_done = 1'b0, d_done = 1'b0;
    int          tb_if_acks = 0, tb_d_acks = 0, ack_cyc_if = 0;
    logic [31:0] ack_if_data;
    int          mreq_cyc_400 = 0, busy_cyc = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (if_ready) begin if_done = 1'b1; tb_if_acks++; ack_cyc_if = cyc; ack_if_data = if_rdata; end
        if (d_ready)  begin d_done = 1'b1; tb_d_acks++; end
        if (m_req && m_addr == 32'h400) mreq_cyc_400++;
        if (busy) busy_cyc++;
        if (m_req && m_gnt && !rst) begin
            acc_log.push_back('{we: m_we, addr: m_addr, wdata: m_wdata});
            rv_cnt = int'($urandom_range(rv_max, rv_min));
            if (m_we) begin
                rv_data = $urandom;
                mem[m_addr] = m_wdata;
            end else begin
                rv_data = mem_rd(m_addr);
            end
        end
        @(posedge clk);
        #1;
        m_rvalid = force_rv;
        m_rdata  = force_rv ? force_data : $urandom;
        force_rv = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                m_rvalid = 1'b1;
                m_rdata  = rv_data;
            end
        end
        m_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (if_done) begin if_req = 1'b0; if_done = 1'b0; end
        if (d_done)  begin d_req = 1'b0;  d_done = 1'b0;  end
        if (!rst && !if_req && int'($urandom_range(99)) < if_pct) begin
            if_req  = 1'b1;
            if_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
        end
        if (!rst && !d_req && int'($urandom_range(99)) < d_pct) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom);
            d_addr  = 32'h2000_0000 | ($urandom & 32'hFFFC);
            d_wdata = $urandom;
        end
    endtask

    task automatic wait_if(input int budget, input string name);
        int tgt = tb_if_acks + 1;
        for (int n = 0; n < budget && tb_if_acks < tgt; n++) tick();
        chk({name, "_if_done"}, 32'(tb_if_acks >= tgt), 32'd1);
    endtask

    task automatic wait_d(input int budget, input string name);
        int tgt = tb_d_acks + 1;
        for (int n = 0; n < budget && tb_d_acks < tgt; n++) tick();
        chk({name, "_d_done"}, 32'(tb_d_acks >= tgt), 32'd1);
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    int          ph = P_FREE;
    int          d_run = 0;
    logic        ow_d = 1'b0;
    logic        e_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
    logic        take_d;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_req",    32'(m_req),    32'd0);
            chk("rst_busy",     32'(busy),     32'd0);
            chk("rst_if_ready", 32'(if_ready), 32'd0);
            chk("rst_d_ready",  32'(d_ready),  32'd0);
            chk("rst_m_addr",   m_addr,        32'd0);
            chk("rst_if_rdata", if_rdata,      32'd0);
            ph = P_FREE; d_run = 0; ow_d = 1'b0; e_we = 1'b0;
            e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            chk("m_req",    32'(m_req),    32'(ph == P_REQ));
            chk("m_we",     32'(m_we),     32'(e_we));
            chk("m_addr",   m_addr,        e_addr);
            chk("m_wdata",  m_wdata,       e_wdata);
            chk("busy",     32'(busy),     32'(ph != P_FREE));
            chk("if_ready", 32'(if_ready), 32'(ph == P_ACK && !ow_d));
            chk("d_ready",  32'(d_ready),  32'(ph == P_ACK && ow_d));
            chk("if_rdata", if_rdata,      e_if_rdata);
            chk("d_rdata",  d_rdata,       e_d_rdata);
            case (ph)
                P_FREE: if (if_req || d_req) begin
                    take_d = d_req && !(if_req && d_run >= MAX_D);
                    if (take_d) begin
                        d_run   = if_req ? ((d_run < MAX_D) ? d_run + 1 : MAX_D) : 0;
                        e_we    = d_we;
                        e_addr  = d_addr;
                        e_wdata = d_wdata;
                    end else begin
                        d_run   = 0;
                        e_we    = 1'b0;
                        e_addr  = if_addr;
                        e_wdata = '0;
                    end
                    ow_d = take_d;
                    ph   = P_REQ;
                end
                P_REQ:  if (m_gnt) ph = P_WAIT;
                P_WAIT: if (m_rvalid) begin
                    if (ow_d) e_d_rdata = m_rdata;
                    else      e_if_rdata = m_rdata;
                    ph = P_ACK;
                end
                default: ph = P_FREE;
            endcase
        end
    end

    // ---------------- directed and random sequences ----------------
    int         t0, a0, b0;
    logic [9:0] pat;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // fetch only, zero-wait memory
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        mem[32'h100] = 32'hDEAD_BEEF;
        b0 = tb_d_acks;
        if_req = 1'b1; if_addr = 32'h100; t0 = cyc;
        wait_if(20, "t1");
        chk("t1_rdata",    ack_if_data,      32'hDEAD_BEEF);
        chk("t1_latency",  ack_cyc_if - t0,  32'd3);
        chk("t1_no_dready", tb_d_acks - b0,  32'd0);

        // simultaneous requests: data store first, then fetch
        acc_log.delete();
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        wait_d(20, "t2");
        wait_if(20, "t2");
        chk("t2_n_acc", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() >= 2) begin
            chk("t2_first_we",    32'(acc_log[0].we), 32'd1);
            chk("t2_first_addr",  acc_log[0].addr,    32'h200);
            chk("t2_first_wdata", acc_log[0].wdata,   32'h55);
            chk("t2_second_we",   32'(acc_log[1].we), 32'd0);
            chk("t2_second_addr", acc_log[1].addr,    32'h300);
            chk("t2_second_wdata", acc_log[1].wdata,  32'h0);
        end

        // both held continuously: streak forces every fifth grant to fetch
        acc_log.delete();
        if_pct = 100; d_pct = 100;
        for (int n = 0; n < 200 && acc_log.size() < 10; n++) tick();
        if_pct = 0; d_pct = 0;
        repeat (20) tick();
        chk("t3_n_acc", 32'(acc_log.size() >= 10), 32'd1);
        pat = '0;
        for (int i = 0; i < 10; i++)
            pat = {pat[8:0], (i < acc_log.size()) && (acc_log[i].addr[31:28] == 4'h2)};
        chk("t3_order", 32'(pat), 32'(10'b1111011110));

        // grant withheld for five cycles
        a0 = tb_if_acks; mreq_cyc_400 = 0;
        gnt_pct = 0; m_gnt = 1'b0;
        if_req = 1'b1; if_addr = 32'h400;
        repeat (5) tick();
        gnt_pct = 100;
        wait_if(20, "t4");
        repeat (4) tick();
        chk("t4_mreq_cycles", mreq_cyc_400,     32'd6);
        chk("t4_one_ready",   tb_if_acks - a0,  32'd1);

        // reset while waiting for the response; late m_rvalid after release
        rv_min = 4; rv_max = 4;
        a0 = tb_if_acks;
        if_req = 1'b1; if_addr = 32'h480;
        tick();
        tick();
        rst = 1'b1; if_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("t5_no_ready", tb_if_acks - a0, 32'd0);
        rv_min = 1; rv_max = 1;
        mem[32'h500] = 32'h1234_5678;
        if_req = 1'b1; if_addr = 32'h500;
        wait_if(20, "t5_next");
        chk("t5_rdata", ack_if_data, 32'h1234_5678);

        // spurious response while idle
        a0 = tb_if_acks; b0 = tb_d_acks; busy_cyc = 0;
        force_rv = 1'b1; force_data = 32'hCAFE_F00D;
        repeat (4) tick();
        chk("t6_if_rdata", if_rdata,         32'h1234_5678);
        chk("t6_busy",     busy_cyc,         32'd0);
        chk("t6_if_acks",  tb_if_acks - a0,  32'd0);
        chk("t6_d_acks",   tb_d_acks - b0,   32'd0);

        // random traffic with varying memory behaviour and one mid-run reset
        a0 = tb_if_acks; b0 = tb_d_acks;
        for (int seg = 0; seg < 30; seg++) begin
            gnt_pct = int'($urandom_range(100, 20));
            rv_min  = 1;
            rv_max  = int'($urandom_range(3, 1));
            if_pct  = int'($urandom_range(90, 10));
            d_pct   = int'($urandom_range(90, 10));
            if (seg == 15) begin
                rst = 1'b1; if_req = 1'b0; d_req = 1'b0; if_done = 1'b0; d_done = 1'b0;
                tick();
                rst = 1'b0;
            end
            repeat (100) tick();
        end
        gnt_pct = 100; rv_min = 1; rv_max = 1; if_pct = 0; d_pct = 0;
        repeat (40) tick();
        chk("rand_if_traffic", 32'(tb_if_acks - a0 > 50), 32'd1);
        chk("rand_d_traffic",  32'(tb_d_acks - b0 > 50),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
